processor_run_ctrl: RTL and testbench

Synthesizable run controller for `processor_top` that replaces the fixed-delay reset/finish sequencing of the simulation bench with a parametrised, cycle-accurate supervisor. It sequences core reset, counts executed cycles, and detects program completion: a store to a mailbox address, a hung PC, or a cycle budget expiring. It sits beside the core, observing its PC and data-memory write port and driving its reset, so the same harness serves both simulation and FPGA bring-up.

---
 rtl/processor_run_ctrl_pkg.sv | 21 ++
 rtl/processor_run_ctrl_if.sv | 29 ++
 rtl/processor_run_ctrl_hang_detector.sv | 45 ++++
 rtl/processor_run_ctrl.sv | 111 +++++++++++
 tb/tb_processor_run_ctrl.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/processor_run_ctrl_pkg.sv
// Shared types and default mailbox constants for the processor run controller.
// Imported by the controller top and its hang detector.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RST_HOLD = 2'd1,
        S_RUN      = 2'd2,
        S_DONE     = 2'd3
    } run_state_t;

    typedef enum logic [1:0] {
        ST_MAILBOX = 2'd0,
        ST_HANG    = 2'd1,
        ST_TIMEOUT = 2'd2
    } run_status_t;

    localparam logic [31:0] DEF_TOHOST_ADDR = 32'h0000_0FFC;
    localparam logic [31:0] DEF_PASS_VALUE  = 32'h0000_0001;

endpackage

// File: rtl/processor_run_ctrl_if.sv
// Harness-side bundle between the run controller and the core/bench.
// The master drives start and core observations; the slave (controller) drives status.
interface processor_run_ctrl_if #(
    parameter int W  = 32,
    parameter int CW = 32
);
    logic          start;
    logic [W-1:0]  pc;
    logic          dmem_we;
    logic [W-1:0]  dmem_addr;
    logic [W-1:0]  dmem_wdata;
    logic          core_rst_n;
    logic          busy;
    logic          done;
    logic          pass;
    logic [1:0]    status;
    logic [W-1:0]  result;
    logic [CW-1:0] cycle_count;

    modport master (
        output start, pc, dmem_we, dmem_addr, dmem_wdata,
        input  core_rst_n, busy, done, pass, status, result, cycle_count
    );

    modport slave (
        input  start, pc, dmem_we, dmem_addr, dmem_wdata,
        output core_rst_n, busy, done, pass, status, result, cycle_count
    );
endinterface

// File: rtl/processor_run_ctrl_hang_detector.sv
// Tracks how many consecutive RUN cycles the PC has repeated its previous value.
// o_hang fires combinationally on the HANG_LIMIT-th consecutive repeat.
module hang_detector
    import run_ctrl_pkg::*;
#(
    parameter int W          = 32,
    parameter int HANG_LIMIT = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_pc,
    output logic         o_hang
);
    localparam int HW = $clog2(HANG_LIMIT + 1);

    logic [W-1:0]  r_prev_pc;
    logic          r_valid;
    logic [HW-1:0] r_cnt;
    logic          w_match;

    // No previous PC exists on the first RUN cycle, so r_valid gates the compare.
    assign w_match = r_valid && (i_pc == r_prev_pc);
    assign o_hang  = w_match && (r_cnt >= HW'(HANG_LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_pc <= '0;
            r_valid   <= 1'b0;
            r_cnt     <= '0;
        end else if (i_clr) begin
            r_prev_pc <= '0;
            r_valid   <= 1'b0;
            r_cnt     <= '0;
        end else if (i_en) begin
            r_prev_pc <= i_pc;
            r_valid   <= 1'b1;
            if (!w_match)
                r_cnt <= '0;
            else if (r_cnt != HW'(HANG_LIMIT))
                r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/processor_run_ctrl.sv
// Run supervisor for processor_top: sequences core reset, counts RUN cycles and
// ends the run on a mailbox store, a stuck PC or an exhausted cycle budget.
module processor_run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int          W           = 32,
    parameter int          CW          = 32,
    parameter int          RST_HOLD    = 4,
    parameter int          MAX_CYCLES  = 50000,
    parameter int          HANG_LIMIT  = 16,
    parameter logic [W-1:0] TOHOST_ADDR = W'(DEF_TOHOST_ADDR),
    parameter logic [W-1:0] PASS_VALUE  = W'(DEF_PASS_VALUE)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    processor_run_ctrl_if.slave  bus
);
    run_state_t    r_state;
    run_status_t   r_status;
    logic [7:0]    r_hold_cnt;
    logic          r_core_rst_n;
    logic          r_busy;
    logic          r_done;
    logic          r_pass;
    logic [W-1:0]  r_result;
    logic [CW-1:0] r_cycle_count;

    logic w_mbox;
    logic w_hang;
    logic w_timeout;

    assign w_mbox    = bus.dmem_we && (bus.dmem_addr == TOHOST_ADDR);
    assign w_timeout = (r_cycle_count == CW'(MAX_CYCLES - 1));

    hang_detector #(
        .W          (W),
        .HANG_LIMIT (HANG_LIMIT)
    ) u_hang (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (r_state == S_RST_HOLD),
        .i_en   (r_state == S_RUN),
        .i_pc   (bus.pc),
        .o_hang (w_hang)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_status      <= ST_MAILBOX;
            r_hold_cnt    <= '0;
            r_core_rst_n  <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_result      <= '0;
            r_cycle_count <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_state       <= S_RST_HOLD;
                        r_hold_cnt    <= '0;
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                        r_pass        <= 1'b0;
                        r_status      <= ST_MAILBOX;
                        r_result      <= '0;
                        r_cycle_count <= '0;
                    end
                end
                S_RST_HOLD: begin
                    // Release lands exactly RST_HOLD edges after the start edge.
                    if (r_hold_cnt == 8'(RST_HOLD - 1)) begin
                        r_state      <= S_RUN;
                        r_core_rst_n <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                S_RUN: begin
                    r_cycle_count <= r_cycle_count + 1'b1;
                    if (w_mbox || w_hang || w_timeout) begin
                        r_state      <= S_DONE;
                        r_core_rst_n <= 1'b0;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                    end
                    if (w_mbox) begin
                        r_status <= ST_MAILBOX;
                        r_result <= bus.dmem_wdata;
                        r_pass   <= (bus.dmem_wdata == PASS_VALUE);
                    end else if (w_hang) begin
                        r_status <= ST_HANG;
                    end else if (w_timeout) begin
                        r_status <= ST_TIMEOUT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.core_rst_n  = r_core_rst_n;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.pass        = r_pass;
    assign bus.status      = r_status;
    assign bus.result      = r_result;
    assign bus.cycle_count = r_cycle_count;
endmodule

// File: tb/tb_processor_run_ctrl.sv
// Directed bench for processor_run_ctrl: reset hold, mailbox pass/fail, hang,
// timeout/priority, asynchronous reset and rerun.
module tb_processor_run_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    processor_run_ctrl_if #(.W(32), .CW(32)) bus ();

    processor_run_ctrl #(
        .W(32), .CW(32), .RST_HOLD(4), .MAX_CYCLES(100), .HANG_LIMIT(16),
        .TOHOST_ADDR(32'h0000_0FFC), .PASS_VALUE(32'h1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // One clock: inputs applied at the falling edge, outputs sampled 1 ns after the rising edge.
    task automatic step(input logic [31:0] p, input logic we, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.pc = p; bus.dmem_we = we; bus.dmem_addr = a; bus.dmem_wdata = d;
        @(posedge clk); #1;
    endtask

    task automatic do_start();
        @(negedge clk);
        bus.start = 1'b1; bus.dmem_we = 1'b0; bus.pc = '0;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic start_run();
        do_start();
        for (int i = 0; i < 4; i++) step(32'h0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.pc = '0; bus.dmem_we = 1'b0; bus.dmem_addr = '0; bus.dmem_wdata = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if ({bus.core_rst_n, bus.busy, bus.done, bus.pass} !== 4'b0000) begin n_fail++;
            $display("FAIL reset_flags got %b exp 0000", {bus.core_rst_n, bus.busy, bus.done, bus.pass}); end
        n_checks++; if (bus.status !== 2'd0 || bus.result !== 32'h0 || bus.cycle_count !== 32'h0) begin n_fail++;
            $display("FAIL reset_data status=%0d result=%h count=%0d exp 0/0/0", bus.status, bus.result, bus.cycle_count); end
        @(negedge clk); rst_n = 1'b1;
        step(32'h0, 1'b0, 32'h0, 32'h0);
        n_checks++; if (bus.busy !== 1'b0 || bus.core_rst_n !== 1'b0) begin n_fail++;
            $display("FAIL idle_hold busy=%b core_rst_n=%b exp 0/0", bus.busy, bus.core_rst_n); end
    endtask

    task automatic test_reset_hold();
        do_start();
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (bus.core_rst_n !== 1'b0 || bus.busy !== 1'b1) begin n_fail++;
                $display("FAIL hold_cycle%0d core_rst_n=%b busy=%b exp 0/1", i, bus.core_rst_n, bus.busy); end
            step(32'h0, 1'b0, 32'h0, 32'h0);
        end
        n_checks++; if (bus.core_rst_n !== 1'b0 || bus.busy !== 1'b1) begin n_fail++;
            $display("FAIL hold_cycle3 core_rst_n=%b busy=%b exp 0/1", bus.core_rst_n, bus.busy); end
        step(32'h0, 1'b0, 32'h0, 32'h0);
        n_checks++; if (bus.core_rst_n !== 1'b1 || bus.busy !== 1'b1 || bus.cycle_count !== 32'd0) begin n_fail++;
            $display("FAIL run_entry core_rst_n=%b busy=%b count=%0d exp 1/1/0", bus.core_rst_n, bus.busy, bus.cycle_count); end
        step(32'h4, 1'b0, 32'h0, 32'h0);
        n_checks++; if (bus.cycle_count !== 32'd1) begin n_fail++;
            $display("FAIL first_count got %0d exp 1", bus.cycle_count); end
        // Finish this run through the mailbox so the next test starts from DONE.
        step(32'h8, 1'b1, 32'h0FFC, 32'h1);
    endtask

    task automatic test_mailbox_pass();
        start_run();
        for (int j = 1; j <= 36; j++) step(32'(4 * j), 1'b0, 32'h0, 32'h0);
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL mbox_early done=%b exp 0", bus.done); end
        step(32'(4 * 37), 1'b1, 32'h0FFC, 32'h1);
        n_checks++; if (bus.done !== 1'b1 || bus.core_rst_n !== 1'b0 || bus.busy !== 1'b0) begin n_fail++;
            $display("FAIL mbox_done done=%b core_rst_n=%b busy=%b exp 1/0/0", bus.done, bus.core_rst_n, bus.busy); end
        n_checks++; if (bus.status !== 2'd0 || bus.pass !== 1'b1 || bus.result !== 32'h1 || bus.cycle_count !== 32'd37) begin n_fail++;
            $display("FAIL mbox_pass status=%0d pass=%b result=%h count=%0d exp 0/1/1/37", bus.status, bus.pass, bus.result, bus.cycle_count); end
        step(32'h0, 1'b1, 32'h0FFC, 32'h7);
        step(32'h0, 1'b0, 32'h0, 32'h0);
        n_checks++; if (bus.done !== 1'b1 || bus.result !== 32'h1 || bus.cycle_count !== 32'd37 || bus.core_rst_n !== 1'b0) begin n_fail++;
            $display("FAIL done_hold done=%b result=%h count=%0d core_rst_n=%b exp 1/1/37/0", bus.done, bus.result, bus.cycle_count, bus.core_rst_n); end
    endtask

    task automatic test_mailbox_fail();
        start_run();
        for (int j = 1; j <= 4; j++) step(32'(4 * j), 1'b0, 32'h0, 32'h0);
        step(32'h14, 1'b1, 32'h0FF8, 32'h1);
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL near_addr done=%b exp 0", bus.done); end
        step(32'h18, 1'b0, 32'h0FFC, 32'h1);
        step(32'h1C, 1'b0, 32'h0, 32'h0);
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL we_low done=%b exp 0", bus.done); end
        step(32'h20, 1'b1, 32'h0FFC, 32'h2A);
        n_checks++; if (bus.done !== 1'b1 || bus.pass !== 1'b0 || bus.result !== 32'h2A || bus.status !== 2'd0 || bus.cycle_count !== 32'd8) begin n_fail++;
            $display("FAIL mbox_fail done=%b pass=%b result=%h status=%0d count=%0d exp 1/0/2a/0/8", bus.done, bus.pass, bus.result, bus.status, bus.cycle_count); end
    endtask

    task automatic test_hang();
        start_run();
        for (int j = 1; j <= 26; j++) begin
            step((j < 10) ? 32'(4 * j) : 32'h40, 1'b0, 32'h0, 32'h0);
            if (j == 25) begin
                n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL hang_early done=%b exp 0", bus.done); end
            end
        end
        n_checks++; if (bus.done !== 1'b1 || bus.status !== 2'd1 || bus.pass !== 1'b0 || bus.cycle_count !== 32'd26) begin n_fail++;
            $display("FAIL hang done=%b status=%0d pass=%b count=%0d exp 1/1/0/26", bus.done, bus.status, bus.pass, bus.cycle_count); end
    endtask

    task automatic test_hang_restart();
        start_run();
        for (int j = 1; j <= 36; j++) begin
            step((j < 10) ? 32'(4 * j) : ((j < 20) ? 32'h40 : 32'h44), 1'b0, 32'h0, 32'h0);
            if (j == 26 || j == 35) begin
                n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL hang_restart_early cycle %0d done=%b exp 0", j, bus.done); end
            end
        end
        n_checks++; if (bus.done !== 1'b1 || bus.status !== 2'd1 || bus.cycle_count !== 32'd36) begin n_fail++;
            $display("FAIL hang_restart done=%b status=%0d count=%0d exp 1/1/36", bus.done, bus.status, bus.cycle_count); end
    endtask

    task automatic test_timeout();
        start_run();
        for (int j = 1; j <= 99; j++) step(32'(4 * j), 1'b0, 32'h0, 32'h0);
        n_checks++; if (bus.done !== 1'b0 || bus.cycle_count !== 32'd99) begin n_fail++;
            $display("FAIL timeout_early done=%b count=%0d exp 0/99", bus.done, bus.cycle_count); end
        step(32'(400), 1'b0, 32'h0, 32'h0);
        n_checks++; if (bus.done !== 1'b1 || bus.status !== 2'd2 || bus.pass !== 1'b0 || bus.cycle_count !== 32'd100) begin n_fail++;
            $display("FAIL timeout done=%b status=%0d pass=%b count=%0d exp 1/2/0/100", bus.done, bus.status, bus.pass, bus.cycle_count); end
    endtask

    task automatic test_priority();
        start_run();
        for (int j = 1; j <= 99; j++) step(32'(4 * j), 1'b0, 32'h0, 32'h0);
        step(32'(400), 1'b1, 32'h0FFC, 32'h1);
        n_checks++; if (bus.done !== 1'b1 || bus.status !== 2'd0 || bus.pass !== 1'b1 || bus.cycle_count !== 32'd100) begin n_fail++;
            $display("FAIL priority done=%b status=%0d pass=%b count=%0d exp 1/0/1/100", bus.done, bus.status, bus.pass, bus.cycle_count); end
    endtask

    task automatic test_async_reset_rerun();
        start_run();
        for (int j = 1; j <= 10; j++) step(32'(4 * j), 1'b0, 32'h0, 32'h0);
        @(negedge clk); #2 rst_n = 1'b0; #1;
        n_checks++; if ({bus.core_rst_n, bus.busy, bus.done, bus.pass} !== 4'b0000 || bus.cycle_count !== 32'd0 || bus.status !== 2'd0 || bus.result !== 32'h0) begin n_fail++;
            $display("FAIL async_reset flags=%b count=%0d status=%0d result=%h exp 0000/0/0/0", {bus.core_rst_n, bus.busy, bus.done, bus.pass}, bus.cycle_count, bus.status, bus.result); end
        @(negedge clk); rst_n = 1'b1;
        start_run();
        for (int j = 1; j <= 5; j++) step(32'(4 * j), 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        bus.start = 1'b1; bus.pc = 32'h18;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n_checks++; if (bus.busy !== 1'b1 || bus.core_rst_n !== 1'b1 || bus.cycle_count !== 32'd6) begin n_fail++;
            $display("FAIL start_in_run busy=%b core_rst_n=%b count=%0d exp 1/1/6", bus.busy, bus.core_rst_n, bus.cycle_count); end
        for (int j = 7; j <= 9; j++) step(32'(4 * j), 1'b0, 32'h0, 32'h0);
        step(32'h28, 1'b1, 32'h0FFC, 32'h55);
        n_checks++; if (bus.done !== 1'b1 || bus.result !== 32'h55 || bus.pass !== 1'b0 || bus.cycle_count !== 32'd10) begin n_fail++;
            $display("FAIL run_after_start done=%b result=%h pass=%b count=%0d exp 1/55/0/10", bus.done, bus.result, bus.pass, bus.cycle_count); end
        do_start();
        n_checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.core_rst_n !== 1'b0 || bus.result !== 32'h0 || bus.cycle_count !== 32'd0 || bus.pass !== 1'b0 || bus.status !== 2'd0) begin n_fail++;
            $display("FAIL rerun_clear done=%b busy=%b core_rst_n=%b result=%h count=%0d pass=%b status=%0d exp 0/1/0/0/0/0/0", bus.done, bus.busy, bus.core_rst_n, bus.result, bus.cycle_count, bus.pass, bus.status); end
        for (int i = 0; i < 4; i++) step(32'h0, 1'b0, 32'h0, 32'h0);
        step(32'h4, 1'b0, 32'h0, 32'h0);
        step(32'h8, 1'b0, 32'h0, 32'h0);
        step(32'hC, 1'b1, 32'h0FFC, 32'h1);
        n_checks++; if (bus.done !== 1'b1 || bus.pass !== 1'b1 || bus.cycle_count !== 32'd3) begin n_fail++;
            $display("FAIL rerun_done done=%b pass=%b count=%0d exp 1/1/3", bus.done, bus.pass, bus.cycle_count); end
    endtask

    initial begin
        test_reset();
        test_reset_hold();
        test_mailbox_pass();
        test_mailbox_fail();
        test_hang();
        test_hang_restart();
        test_timeout();
        test_priority();
        test_async_reset_rerun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
